// File: rtl/foc_loop_sequencer.sv
// rtl/foc_loop_sequencer.sv - FOC loop tick scheduler, launch-frame snapshot and PID coefficient write queue
module foc_loop_sequencer #(
   parameter int D_WIDTH      = 19,
   parameter int Q_BITS       = 15,
   parameter int VALID_CYCLES = 4,
   parameter int TIMEOUT      = 256,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               enable,
   input  logic [D_WIDTH-1:0] loop_period,
   input  logic [D_WIDTH-1:0] angle_in,
   input  logic [D_WIDTH-1:0] currA_in,
   input  logic [D_WIDTH-1:0] currB_in,
   input  logic [D_WIDTH-1:0] currC_in,
   input  logic [D_WIDTH-1:0] currT_in,
   input  logic               cfg_wen,
   input  logic               cfg_sel,
   input  logic [1:0]         cfg_addr,
   input  logic [D_WIDTH-1:0] cfg_data,
   output logic               cfg_ready,
   output logic               dp_valid,
   input  logic               dp_ready,
   output logic [D_WIDTH-1:0] dp_angle,
   output logic [D_WIDTH-1:0] dp_currA,
   output logic [D_WIDTH-1:0] dp_currB,
   output logic [D_WIDTH-1:0] dp_currC,
   output logic [D_WIDTH-1:0] dp_currT,
   output logic               pid_d_wen,
   output logic               pid_q_wen,
   output logic [D_WIDTH-1:0] pid_d_addr,
   output logic [D_WIDTH-1:0] pid_q_addr,
   output logic [D_WIDTH-1:0] pid_d_data,
   output logic [D_WIDTH-1:0] pid_q_data,
   output logic               overrun,
   output logic               timeout,
   input  logic               clear_status,
   output logic [15:0]        loop_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = D_WIDTH + 3;
   localparam int VW = $clog2(VALID_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [VW-1:0] V_LAST = VW'(VALID_CYCLES - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   // Q_BITS only describes the word format seen by the datapath.
   if (Q_BITS >= D_WIDTH) begin : g_bad_qbits
      $error("Q_BITS must be smaller than D_WIDTH");
   end

   typedef enum logic [1:0] {S_IDLE, S_CFG, S_LAUNCH, S_WAIT} state_t;
   state_t state, state_n;

   logic [D_WIDTH-1:0] period_cnt;
   logic               tick_pending, ready_q;
   logic [VW-1:0]      valid_cnt;
   logic [TW-1:0]      wait_cnt;
   logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
   logic [AW:0]        wr_ptr, rd_ptr;
   logic               run, tick, fifo_empty, fifo_full, push, pop, launch;
   logic               ready_rise, overrun_set, timeout_set;
   logic [EW-1:0]      head;
   logic               head_sel;
   logic [D_WIDTH-1:0] head_addr, head_data;

   assign run         = enable && (loop_period != '0);
   assign tick        = run && (period_cnt == loop_period - D_WIDTH'(1));
   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cfg_ready   = !fifo_full;
   assign push        = cfg_wen && !fifo_full;
   assign pop         = (state == S_CFG);
   assign head        = fifo_mem[rd_ptr[AW-1:0]];
   assign head_sel    = head[EW-1];
   assign head_addr   = {{(D_WIDTH-2){1'b0}}, head[D_WIDTH+1:D_WIDTH]};
   assign head_data   = head[D_WIDTH-1:0];
   // Pending coefficient writes always win over a pending launch.
   assign launch      = (state == S_IDLE) && fifo_empty && tick_pending;
   assign ready_rise  = dp_ready && !ready_q;
   assign overrun_set = tick && (tick_pending || state == S_LAUNCH || state == S_WAIT);
   assign timeout_set = (state == S_WAIT) && !ready_rise && (wait_cnt == T_LAST);

   always_ff @(posedge clk) begin
      if (!rstb) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (!fifo_empty)       state_n = S_CFG;
            else if (tick_pending) state_n = S_LAUNCH;
         end
         S_CFG:    state_n = S_IDLE;
         S_LAUNCH: if (valid_cnt == V_LAST) state_n = S_WAIT;
         S_WAIT:   if (ready_rise || wait_cnt == T_LAST) state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= {cfg_sel, cfg_addr, cfg_data};
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         period_cnt   <= '0;
         tick_pending <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         ready_q      <= 1'b0;
         valid_cnt    <= '0;
         wait_cnt     <= '0;
         dp_valid     <= 1'b0;
         dp_angle     <= '0;
         dp_currA     <= '0;
         dp_currB     <= '0;
         dp_currC     <= '0;
         dp_currT     <= '0;
         pid_d_wen    <= 1'b0;
         pid_q_wen    <= 1'b0;
         pid_d_addr   <= '0;
         pid_q_addr   <= '0;
         pid_d_data   <= '0;
         pid_q_data   <= '0;
         overrun      <= 1'b0;
         timeout      <= 1'b0;
         loop_count   <= '0;
      end else begin
         period_cnt <= (!run || tick) ? '0 : period_cnt + D_WIDTH'(1);
         if (!run || launch)             tick_pending <= 1'b0;
         else if (tick && !overrun_set)  tick_pending <= 1'b1;

         wr_ptr    <= wr_ptr + (AW+1)'(push);
         rd_ptr    <= rd_ptr + (AW+1)'(pop);
         ready_q   <= dp_ready;
         valid_cnt <= (state == S_LAUNCH) ? valid_cnt + VW'(1) : '0;
         wait_cnt  <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;

         // Registered so dp_valid is high exactly while the FSM sits in LAUNCH.
         dp_valid <= (state_n == S_LAUNCH);
         if (launch) begin
            dp_angle <= angle_in;
            dp_currA <= currA_in;
            dp_currB <= currB_in;
            dp_currC <= currC_in;
            dp_currT <= currT_in;
         end

         pid_d_wen <= (state_n == S_CFG) && !head_sel;
         pid_q_wen <= (state_n == S_CFG) && head_sel;
         if (state_n == S_CFG && !head_sel) begin
            pid_d_addr <= head_addr;
            pid_d_data <= head_data;
         end
         if (state_n == S_CFG && head_sel) begin
            pid_q_addr <= head_addr;
            pid_q_data <= head_data;
         end

         if (state == S_WAIT && ready_rise) loop_count <= loop_count + 16'd1;
         overrun <= overrun_set || (overrun && !clear_status);
         timeout <= timeout_set || (timeout && !clear_status);
      end
   end
endmodule

// File: doc/foc_loop_sequencer.md
# foc_loop_sequencer

Cycle scheduler for the FOC datapath (`top`). It generates the periodic control-loop trigger and snapshots resolver angle, phase currents and torque target into a stable launch frame. It drives the datapath `valid`/`ready` handshake. It also queues host PID coefficient writes and applies them only between loop iterations, never while an iteration is in flight. It sits between the host/ECU register interface plus sampling front end and the `top` instance.

## Interface
Parameters:
- D_WIDTH, 19, datapath word width
- Q_BITS, 15, fractional bits (pass-through only; no arithmetic here)
- VALID_CYCLES, 4, cycles `dp_valid` is held per launch
- TIMEOUT, 256, max cycles waiting for `dp_ready` rising edge
- FIFO_DEPTH, 4, coefficient write queue depth (power of 2)

Ports:
- clk  in  1  system clock
- rstb  in  1  reset; one clock, synchronous, active-low
- enable  in  1  loop enable
- loop_period  in  D_WIDTH  loop period in clk cycles; 0 = no ticks
- angle_in, currA_in, currB_in, currC_in  in  D_WIDTH each  live samples
- currT_in  in  D_WIDTH signed  live torque target
- cfg_wen  in  1  host coefficient write strobe
- cfg_sel  in  1  0 = d-axis PID, 1 = q-axis PID
- cfg_addr  in  2  coefficient index
- cfg_data  in  D_WIDTH  coefficient value
- cfg_ready  out  1  queue not full; a write is accepted when `cfg_wen & cfg_ready`
- dp_valid  out  1  to `top.valid`
- dp_ready  in  1  from `top.ready`
- dp_angle, dp_currA, dp_currB, dp_currC, dp_currT  out  D_WIDTH  launch frame
- pid_d_wen, pid_q_wen  out  1  coefficient write enables
- pid_d_addr, pid_q_addr  out  D_WIDTH  zero-extended `cfg_addr`
- pid_d_data, pid_q_data  out  D_WIDTH  coefficient data
- overrun  out  1  sticky: a tick was lost
- timeout  out  1  sticky: `dp_ready` never rose
- clear_status  in  1  clears `overrun` and `timeout`
- loop_count  out  16  completed iterations, wraps at 2^16

## Operation
- **Period counter.** While `enable` and `loop_period != 0`, the counter counts 0..loop_period-1 and wraps. The wrap cycle is a tick. When `enable` is low or `loop_period == 0`, the counter is held at 0 and `tick_pending` is cleared.
- **Tick latching.** A tick sets `tick_pending`.
  - A tick while `tick_pending` is already set, or while in LAUNCH/WAIT, sets `overrun` and the tick is dropped.
  - A tick in IDLE/CFG is legal.
- **Coefficient queue.** FIFO of {sel, addr, data}. `cfg_ready = !full`, combinational. A push while full is ignored. A pop and a push in the same cycle are both honoured.
- **FSM states.**
  - IDLE: if the FIFO is non-empty, go to CFG. Else if `tick_pending`, latch all five inputs into `dp_*`, clear `tick_pending`, and go to LAUNCH. Config writes always drain before a launch.
  - CFG: pop one entry. For that one cycle, assert `pid_d_wen` (sel=0) or `pid_q_wen` (sel=1) with addr/data. Return to IDLE.
  - LAUNCH: `dp_valid = 1` for exactly VALID_CYCLES cycles, then go to WAIT.
  - WAIT: detect a `dp_ready` rising edge using a registered previous value. On the edge, increment `loop_count` and go to IDLE. After TIMEOUT cycles without an edge, set `timeout` and go to IDLE with no count increment.
- **Frame stability.** The `dp_*` frame holds from launch until the next launch.
- **Enable low mid-iteration.** Deasserting `enable` does not abort LAUNCH/WAIT; the in-flight iteration completes or times out.
- **Status flags.** A simultaneous set and `clear_status` results in the flag being set.
- **Reset.** Reset at any point returns the FSM to IDLE, empties the FIFO and clears the counter, `tick_pending` and `loop_count`.

## Timing
- Reset values:
  - `dp_valid`, `pid_*_wen`, `overrun`, `timeout` = 0.
  - `dp_*`, `pid_*_addr`, `pid_*_data`, `loop_count` = 0.
  - `cfg_ready` = 1.
- Tick latency: with the counter at loop_period-1 in cycle T and an empty FIFO, `tick_pending` is set in T+1 and `dp_valid` first goes high in T+2.
- Each queued write adds 2 cycles (CFG plus return to IDLE) before a launch.
- Minimum period without overrun is 2 + VALID_CYCLES + the datapath latency to `ready` rising, plus 2 cycles per queued write.
- `pid_*_wen` is never high in the same cycle as `dp_valid`, nor while in WAIT.
- All outputs are registered except `cfg_ready`.

## Test plan
- **Reset check.** Reset, `enable=1`, `loop_period=100`, `dp_ready` pulses 20 cycles after `dp_valid` falls.
  - `dp_valid` is high for 4 cycles, every 100 cycles.
  - `loop_count` increments each loop.
  - Frame equals the inputs sampled at the launch cycle (e.g. currA=16384, currB=-16384).
- **Coefficient queue.** Push d/addr0/4096, q/addr0/4096, d/addr1/512, q/addr1/512 while in WAIT.
  - No `pid_*_wen` until WAIT exits.
  - The 4 writes then appear in order on alternating CFG cycles, before the next `dp_valid`.
  - A 5th push while full is dropped and `cfg_ready` is 0.
- **Overrun.** `loop_period=10` with the datapath taking 30 cycles: `overrun` sets and the launch rate is one per iteration. `clear_status` clears the flag.
- **Timeout.** `dp_ready` is held low: `timeout` sets exactly 256 cycles after WAIT entry, the FSM returns to IDLE, `loop_count` is unchanged, and the next tick launches normally.
- **Enable low and reset mid-operation.**
  - Drop `enable` during LAUNCH: the iteration completes and no further `dp_valid` occurs.
  - Assert `rstb=0` for one cycle during WAIT: all outputs return to reset values on the next edge.
  - `loop_period=0`: no ticks occur.
